// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle synchronous instruction SRAM,
// presents one {pc, inst, adef} to decode over a valid/ready handshake.
// Latency: 2 cycles from reset release/handshake/redirect to fs_valid (1 cycle on a
// misaligned PC). Backpressure: the presented instruction is held until decode accepts it.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   inst_sram_we/addr/wdata    SRAM request (read-only; addr always equals the PC register)
//   inst_sram_rdata            word for the address presented in the previous cycle
//   fs_valid, ds_ready         handshake to decode
//   fs_pc, fs_inst, fs_adef    presented instruction and its address-error flag
//   br_valid, br_target        redirect from decode/execute (highest priority)
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter logic [31:0] NOP_INST = 32'h03400000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_valid,
  input  logic        ds_ready,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adef,
  input  logic        br_valid,
  input  logic [31:0] br_target
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_RESP = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_q;

  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_REQ;
      pc_q     <= RESET_PC;
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC;
      fs_inst  <= 32'h0;
      fs_adef  <= 1'b0;
    end else if (br_valid) begin
      // Redirect wins everywhere: an in-flight SRAM word is discarded, a held
      // instruction is dropped unless decode takes it in this same cycle.
      pc_q     <= br_target;
      state    <= S_REQ;
      fs_valid <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (pc_q[1:0] != 2'b00) begin
            // Misaligned: skip the SRAM and present a NOP flagged as address error.
            fs_valid <= 1'b1;
            fs_adef  <= 1'b1;
            fs_inst  <= NOP_INST;
            fs_pc    <= pc_q;
            state    <= S_HOLD;
          end else begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          fs_inst  <= inst_sram_rdata;
          fs_pc    <= pc_q;
          fs_adef  <= 1'b0;
          fs_valid <= 1'b1;
          state    <= S_HOLD;
        end
        S_HOLD: begin
          if (fs_valid && ds_ready) begin
            fs_valid <= 1'b0;
            pc_q     <= pc_q + 32'd4;
            state    <= S_REQ;
          end
        end
        default: begin
          state    <= S_REQ;
          fs_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
